// File: rtl/acu_pkg.sv
// Shared ACU definitions: operation selects, datapath widths, sequencer state encoding.
package acu_pkg;

  localparam int unsigned CNT_W     = 16;
  localparam int unsigned OP_W      = 16;
  localparam int unsigned ACU_W     = 32;
  localparam int unsigned ACU_SUM_W = 33;
  localparam int unsigned ACU_SEL_W = 4;

  localparam logic [ACU_SEL_W-1:0] ACU_SEL_ADD = 4'h0;
  localparam logic [ACU_SEL_W-1:0] ACU_SEL_MUL = 4'h1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_MUL   = 3'd2,
    ST_ADD   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic             ovf;
    logic [ACU_W-1:0] data;
  } res_t;

endpackage

// File: rtl/acu_mac_seq_if.sv
// Operand stream, result port and ACU operand/result buses of the MAC sequencer.
interface acu_mac_seq_if;
  import acu_pkg::*;

  logic                 op_valid_i;
  logic                 op_ready_o;
  logic [OP_W-1:0]      op_a_i;
  logic [OP_W-1:0]      op_b_i;

  logic                 res_valid_o;
  logic                 res_ready_i;
  logic [ACU_W-1:0]     res_data_o;
  logic                 res_ovf_o;

  logic [ACU_W-1:0]     acu_a_o;
  logic [ACU_W-1:0]     acu_b_o;
  logic [ACU_SEL_W-1:0] acu_sel_o;
  logic [ACU_W-1:0]     acu_prod_i;
  logic [ACU_SUM_W-1:0] acu_sum_i;

  modport master (
    input  op_valid_i, op_a_i, op_b_i, res_ready_i, acu_prod_i, acu_sum_i,
    output op_ready_o, res_valid_o, res_data_o, res_ovf_o, acu_a_o, acu_b_o, acu_sel_o
  );

  modport slave (
    output op_valid_i, op_a_i, op_b_i, res_ready_i, acu_prod_i, acu_sum_i,
    input  op_ready_o, res_valid_o, res_data_o, res_ovf_o, acu_a_o, acu_b_o, acu_sel_o
  );

endinterface

// File: rtl/acu_mac_seq.sv
// Dot-product sequencer: fetches operand pairs, alternates ACU multiply/add phases,
// returns the accumulated sum with a sticky carry flag.
module acu_mac_seq
  import acu_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic [ACU_W-1:0] acc_init_i,
  input  logic             abort_i,
  output logic             busy_o,
  acu_mac_seq_if.master    bus
);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     len_q, len_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [ACU_W-1:0]     acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  res_t                 res_q, res_d;
  logic                 busy_q, busy_d;
  logic                 op_ready_q, op_ready_d;
  logic                 res_valid_q, res_valid_d;
  // acu_a_q doubles as the product register while in ADD
  logic [ACU_W-1:0]     acu_a_q, acu_a_d;
  logic [ACU_W-1:0]     acu_b_q, acu_b_d;
  logic [ACU_SEL_W-1:0] acu_sel_q, acu_sel_d;

  // Next-state and next-output decode; outputs are registered from the next state
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    res_d     = res_q;
    acu_a_d   = '0;
    acu_b_d   = '0;
    acu_sel_d = ACU_SEL_ADD;
    cnt_inc   = cnt_q + CNT_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          len_d = len_i;
          acc_d = acc_init_i;
          cnt_d = '0;
          ovf_d = 1'b0;
          if (len_i == '0) begin
            state_d    = ST_DONE;
            res_d.ovf  = 1'b0;
            res_d.data = acc_init_i;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (bus.op_valid_i) begin
          state_d   = ST_MUL;
          acu_a_d   = ACU_W'(bus.op_a_i);
          acu_b_d   = ACU_W'(bus.op_b_i);
          acu_sel_d = ACU_SEL_MUL;
        end
      end
      ST_MUL: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ADD;
          acu_a_d = bus.acu_prod_i;
          acu_b_d = acc_q;
        end
      end
      ST_ADD: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = bus.acu_sum_i[ACU_W-1:0];
          ovf_d = ovf_q | bus.acu_sum_i[ACU_W];
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d    = ST_DONE;
            res_d.ovf  = ovf_d;
            res_d.data = acc_d;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        if (abort_i || bus.res_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d      = (state_d != ST_IDLE);
    op_ready_d  = (state_d == ST_FETCH);
    res_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      res_q       <= '0;
      busy_q      <= 1'b0;
      op_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      acu_a_q     <= '0;
      acu_b_q     <= '0;
      acu_sel_q   <= ACU_SEL_ADD;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      res_q       <= res_d;
      busy_q      <= busy_d;
      op_ready_q  <= op_ready_d;
      res_valid_q <= res_valid_d;
      acu_a_q     <= acu_a_d;
      acu_b_q     <= acu_b_d;
      acu_sel_q   <= acu_sel_d;
    end
  end

  assign busy_o          = busy_q;
  assign bus.op_ready_o  = op_ready_q;
  assign bus.res_valid_o = res_valid_q;
  assign bus.res_data_o  = res_q.data;
  assign bus.res_ovf_o   = res_q.ovf;
  assign bus.acu_a_o     = acu_a_q;
  assign bus.acu_b_o     = acu_b_q;
  assign bus.acu_sel_o   = acu_sel_q;

endmodule

// File: tb/tb_acu_mac_seq.sv
// Scoreboard bench for acu_mac_seq with an exact combinational ACU model.
module tb_acu_mac_seq;
  import acu_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] len_v;
  logic [ACU_W-1:0] acc_init;
  logic             abort;
  logic             busy;

  acu_mac_seq_if bus();

  acu_mac_seq dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .len_i      (len_v),
    .acc_init_i (acc_init),
    .abort_i    (abort),
    .busy_o     (busy),
    .bus        (bus)
  );

  // Exact ACU: full product and 33-bit sum
  assign bus.acu_prod_i = bus.acu_a_o * bus.acu_b_o;
  assign bus.acu_sum_i  = ACU_SUM_W'(bus.acu_a_o) + ACU_SUM_W'(bus.acu_b_o);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [ACU_W-1:0] data;
    logic             ovf;
    int               lat;
    int               t0;
  } exp_t;

  typedef struct {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    int              dly;
  } pair_t;

  exp_t  sb[$];
  pair_t op_q[$];

  // Operand feeder: each queued pair waits dly cycles at the head, then is offered
  logic hs_pending = 1'b0;
  int   consumed = 0;
  int   op_ready_cnt = 0;

  always @(negedge clk) hs_pending = bus.op_valid_i && bus.op_ready_o && !abort;

  initial begin : feeder
    pair_t p;
    bus.op_valid_i = 1'b0;
    bus.op_a_i     = '0;
    bus.op_b_i     = '0;
    forever begin
      @(posedge clk); #1;
      if (hs_pending && op_q.size() > 0) begin
        void'(op_q.pop_front());
        consumed++;
      end
      if (op_q.size() > 0) begin
        p = op_q[0];
        if (p.dly > 0) begin
          bus.op_valid_i = 1'b0;
          p.dly--;
          op_q[0] = p;
        end else begin
          bus.op_valid_i = 1'b1;
          bus.op_a_i     = p.a;
          bus.op_b_i     = p.b;
        end
      end else begin
        bus.op_valid_i = 1'b0;
      end
    end
  end

  // Result monitor: latency on first sight, hold while stalled, value on handshake
  exp_t mon_e;
  bit   seen_valid = 1'b0;

  always @(negedge clk) begin
    if (rst_n && bus.op_ready_o) op_ready_cnt++;
    if (rst_n && bus.res_valid_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 64'(bus.res_data_o), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        mon_e = sb[0];
        if (!seen_valid) begin
          seen_valid = 1'b1;
          if (mon_e.lat != 0) chk("latency", 64'(cyc - mon_e.t0), 64'(mon_e.lat));
        end
        if (bus.res_ready_i) begin
          chk("res_data", 64'(bus.res_data_o), 64'(mon_e.data));
          chk("res_ovf",  64'(bus.res_ovf_o),  64'(mon_e.ovf));
          void'(sb.pop_front());
          seen_valid = 1'b0;
        end else begin
          chk("res_hold", 64'(bus.res_data_o), 64'(mon_e.data));
        end
      end
    end
  end

  task automatic start_job(input logic [CNT_W-1:0] len, input logic [ACU_W-1:0] init,
                           input bit push, input logic [ACU_W-1:0] ed, input bit eo, input int el);
    exp_t e;
    @(posedge clk); #1;
    start    = 1'b1;
    len_v    = len;
    acc_init = init;
    if (push) begin
      e.data = ed; e.ovf = eo; e.lat = el; e.t0 = cyc;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    chk(nm, 64'(ok), 64'd1);
  endtask

  // Waits for the nth cycle spent in the MUL or ADD phase identified by sel
  task automatic wait_phase(input logic [ACU_SEL_W-1:0] sel, input int nth, output bit ok);
    int seen = 0;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (busy && !bus.op_ready_o && !bus.res_valid_o && bus.acu_sel_o == sel) begin
        seen++;
        if (seen == nth) ok = 1'b1;
      end
    end
  endtask

  task automatic chk_outputs_idle(input string nm);
    chk({nm, "_busy"},      64'(busy),            64'd0);
    chk({nm, "_op_ready"},  64'(bus.op_ready_o),  64'd0);
    chk({nm, "_res_valid"}, 64'(bus.res_valid_o), 64'd0);
    chk({nm, "_acu_a"},     64'(bus.acu_a_o),     64'd0);
    chk({nm, "_acu_b"},     64'(bus.acu_b_o),     64'd0);
    chk({nm, "_acu_sel"},   64'(bus.acu_sel_o),   64'(ACU_SEL_ADD));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    bit ok;
    int pr0, c0;
    rst_n = 1'b0; start = 1'b0; len_v = '0; acc_init = '0; abort = 1'b0;
    bus.res_ready_i = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk_outputs_idle("reset");
    chk("reset_res_data", 64'(bus.res_data_o), 64'd0);
    chk("reset_res_ovf",  64'(bus.res_ovf_o),  64'd0);
    @(negedge clk) rst_n = 1'b1;

    // Three pairs: 10 + 6 + 20 + 42
    op_q.push_back('{16'd2, 16'd3, 0});
    op_q.push_back('{16'd4, 16'd5, 0});
    op_q.push_back('{16'd6, 16'd7, 0});
    start_job(16'd3, 32'd10, 1, 32'd78, 1'b0, 10);
    wait_idle("t1_idle");

    // Empty job returns the initial accumulator next cycle
    pr0 = op_ready_cnt;
    start_job(16'd0, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 1'b0, 1);
    wait_idle("t2_idle");
    chk("t2_no_op_ready", 64'(op_ready_cnt - pr0), 64'd0);

    // Wrap with carry: 0xFFFFFFF0 + 32
    op_q.push_back('{16'd1, 16'd32, 0});
    start_job(16'd1, 32'hFFFF_FFF0, 1, 32'h0000_0010, 1'b1, 4);
    wait_idle("t3_idle");

    // Operand and result stalls; a stray start while busy must be ignored
    c0 = consumed;
    bus.res_ready_i = 1'b0;
    start_job(16'd2, 32'd1000, 1, 32'd21035, 1'b0, 0);
    op_q.push_back('{16'd5,   16'd7,   5});
    op_q.push_back('{16'd100, 16'd200, 5});
    op_q.push_back('{16'd9,   16'd9,   0});
    @(posedge clk); #1; start = 1'b1; len_v = '0; acc_init = 32'h1234_5678;
    @(posedge clk); #1; start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (bus.res_valid_o) ok = 1'b1;
    end
    chk("t4_res_valid_seen", 64'(ok), 64'd1);
    repeat (4) @(posedge clk);
    #1 bus.res_ready_i = 1'b1;
    wait_idle("t4_idle");
    repeat (2) @(posedge clk);
    #1;
    chk("t4_consumed", 64'(consumed - c0), 64'd2);
    chk("t4_leftover", 64'(op_q.size()), 64'd1);
    chk("t4_still_idle", 64'(busy), 64'd0);
    op_q.delete();

    // Abort in ADD of element 1 of a len=4 job
    op_q.push_back('{16'd1, 16'd1, 0});
    op_q.push_back('{16'd2, 16'd2, 0});
    op_q.push_back('{16'd3, 16'd3, 0});
    op_q.push_back('{16'd4, 16'd4, 0});
    start_job(16'd4, 32'd0, 0, 32'd0, 1'b0, 0);
    wait_phase(ACU_SEL_ADD, 2, ok);
    chk("t5_reach_add", 64'(ok), 64'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    op_q.delete();
    chk("t5_abort_busy",  64'(busy),            64'd0);
    chk("t5_abort_valid", 64'(bus.res_valid_o), 64'd0);
    repeat (4) @(posedge clk);
    op_q.push_back('{16'd3, 16'd3, 0});
    start_job(16'd1, 32'd0, 1, 32'd9, 1'b0, 4);
    wait_idle("t5_idle");

    // Abort beats an operand handshake in FETCH
    op_q.push_back('{16'd7, 16'd7, 0});
    start_job(16'd1, 32'd0, 0, 32'd0, 1'b0, 0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    op_q.delete();
    chk_outputs_idle("t5b_abort_fetch");
    repeat (3) @(posedge clk);

    // Reset mid-MUL with start held high through reset
    op_q.push_back('{16'd10,     16'd10,     0});
    op_q.push_back('{16'hFFFF, 16'hFFFF, 0});
    start_job(16'd2, 32'd5, 0, 32'd0, 1'b0, 0);
    wait_phase(ACU_SEL_MUL, 1, ok);
    chk("t6_reach_mul", 64'(ok), 64'd1);
    rst_n = 1'b0;
    start = 1'b1;
    len_v = 16'd1;
    #1;
    chk_outputs_idle("t6_reset");
    chk("t6_reset_res_data", 64'(bus.res_data_o), 64'd0);
    op_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_post_reset_busy", 64'(busy), 64'd0);
    op_q.push_back('{16'd10,     16'd10,     0});
    op_q.push_back('{16'hFFFF, 16'hFFFF, 0});
    start_job(16'd2, 32'd5, 1, 32'hFFFE_006A, 1'b0, 7);
    wait_idle("t6_idle");

    repeat (3) @(posedge clk); #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
